keypad_scan: RTL and testbench
==============================

# keypad_scan

Scans the Pmod 4x4 hex keypad, debounces it and produces the single-cycle `newKey` strobe and 5-bit `keyCode` that the lock control FSM consumes. It drives the keypad columns one at a time and samples the synchronised rows. A key is reported only after it has been seen alone and stable for a configurable number of full scans. It sits between the keypad pins and the control FSM and runs on the same 5 MHz clock.

## Interface
- `SETTLE_CYCLES`, default 5000: clock cycles each column is driven (1 ms at 5 MHz). Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full-scan results required to accept a press or a release. Must be ≥ 2.
- `clock` input, 1 bit: system clock, 5 MHz, rising-edge.
- `reset` input, 1 bit: synchronous, active-high.
- `row` input, 4 bits: keypad rows, active-low, pulled up off-chip, asynchronous.
- `col` output, 4 bits: keypad column drive, active-low one-hot.
- `newKey` output, 1 bit: one-cycle strobe when a debounced press is accepted.
- `keyCode` output, 5 bits: code of the last accepted key, held until the next accepted key.

## Operation
- **Row synchroniser.** `row` passes through two flip-flops before use. The synchroniser resets to 4'b1111.
- **Column scan.** A column counter counts 0..3. Each column is held for `SETTLE_CYCLES` cycles and then the scan advances: 3 wraps to 0.
  - `col` = ~(1 << column).
  - On the last cycle of each column period, the synchronised rows are latched into that column's 4 bits of a 16-bit key map (1 = pressed).
- **Key layout** (column c, row r):
  - c0 = 1,4,7,0
  - c1 = 2,5,8,F
  - c2 = 3,6,9,E
  - c3 = A,B,C,D
- **Scan evaluation.** At the end of column 3 (end of full scan), the key map is classified:
  - NONE: zero bits set.
  - SINGLE(k): exactly one bit set.
  - MULTI: two or more bits set.
- **Code mapping.**
  - Digits 0-9 map to {1'b1, digit}.
  - Hex keys map to {1'b0, value}: A=01010, B=01011, C=01100 (clear), D=01101, E=00100 (enter), F=01111.
- **Debounce FSM.** It updates only at scan evaluation and holds otherwise.
  - IDLE: SINGLE(k) → cand=k, cnt=1, go PRESS. NONE or MULTI → stay.
  - PRESS: SINGLE(cand) → cnt+1. When cnt reaches `DEBOUNCE_SCANS`, assert `newKey`, load `keyCode` from cand, go HELD. NONE, MULTI or another key → IDLE, cnt=0.
  - HELD: NONE → cnt=1, go RELEASE. Any other result → stay. There is no auto-repeat and no report of a second key while held.
  - RELEASE: NONE → cnt+1. When cnt reaches `DEBOUNCE_SCANS` → IDLE. Any key seen → HELD.
- `cnt` is sized to hold `DEBOUNCE_SCANS` and never wraps.

## Timing
- **Reset values:**
  - `col` = 4'b1110 (column 0 driven).
  - Column counter and cycle counter = 0.
  - Key map, cand and cnt = 0.
  - FSM = IDLE.
  - `newKey` = 0.
  - `keyCode` = 5'b00000.
- **Full scan** = 4×`SETTLE_CYCLES` cycles. After reset, the first evaluation occurs on cycle 4×`SETTLE_CYCLES`.
- **Press latency.** A key held stably from before a scan start produces `newKey` registered one cycle after the `DEBOUNCE_SCANS`-th matching evaluation.
- **`newKey`** is high exactly one cycle per accepted press. `keyCode` changes in that same cycle and is stable thereafter.
- **Row sampling.** Sampling on the last cycle of a column leaves ≥ 2 cycles of synchroniser latency inside the settle window. A row change in the final 2 cycles of a column may be missed for that scan; this is acceptable.
- **Reset mid-operation.** Reset takes priority over all activity. Any `newKey` pending in the same cycle is suppressed. Every state returns to its reset values on the next edge, and a key still held after reset is reported again after a full debounce.
- **Simultaneous events.** A press reaching `DEBOUNCE_SCANS` with MULTI on that evaluation is rejected (→ IDLE).

## Test plan
Bench parameters: `SETTLE_CYCLES`=4, `DEBOUNCE_SCANS`=3 (scan = 16 cycles).
- **Reset.** Assert reset, release, no keys → `col` cycles 1110, 1101, 1011, 0111 at 4 cycles each. `newKey` stays 0 and `keyCode`=00000 for 200 cycles.
- **Single press.** Model key "1" (c0,r0) pressed and held → exactly one `newKey` pulse after the 3rd evaluation (cycle 48+1), with `keyCode`=10001. Holding for 10 more scans gives no further pulses.
- **Digit and control keys.** Press-release sequence "0", C, E (each held 5 scans, released 5 scans) → three pulses with `keyCode` 10000, 01100, 00100 in order.
- **Bounce.** Key "5" present for 2 scans, absent for 1, then present for 3 → a single pulse, only after the 3 consecutive scans, with `keyCode`=10101.
- **Multi-key.** Keys "2" and "A" held together for 6 scans → no pulse. Releasing "A" afterwards → pulse with `keyCode`=10010 after 3 further scans.
- **Release and reset.** Key "9" held, released for only 2 scans, then pressed again → no second pulse. Asserting reset while "9" is still held → outputs return to reset values and `newKey`/`keyCode`=11001 re-reported after 3 scans.

Source files
------------

// File: rtl/keypad_scan.sv
// Pmod 4x4 keypad scanner: drives columns one at a time, synchronises the rows and
// debounces whole-scan results into a one-cycle newKey strobe plus a held keyCode.
module keypad_scan #(
    parameter int SETTLE_CYCLES  = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       newKey,
    output logic [4:0] keyCode
);

    localparam int CYC_W = $clog2(SETTLE_CYCLES);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESS   = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [3:0]       row_meta_q, row_sync_q;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [15:0]      keymap_q, keymap_d;
    logic             eval_q, eval_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             newkey_q, newkey_d;
    logic [4:0]       keycode_q, keycode_d;

    logic             col_last;
    logic [4:0]       key_count;
    logic [3:0]       key_idx;
    logic             scan_none, scan_single;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [4:0] count_keys(input logic [15:0] m);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0000, m[i]};
        end
        return n;
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [3:0] key_index(input logic [15:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Map index is column*4 + row; digits carry a leading 1, letters a leading 0.
    function automatic logic [4:0] key_code(input logic [3:0] idx);
        logic [4:0] code;
        case (idx)
            4'd0:    code = 5'b10001;
            4'd1:    code = 5'b10100;
            4'd2:    code = 5'b10111;
            4'd3:    code = 5'b10000;
            4'd4:    code = 5'b10010;
            4'd5:    code = 5'b10101;
            4'd6:    code = 5'b11000;
            4'd7:    code = 5'b01111;
            4'd8:    code = 5'b10011;
            4'd9:    code = 5'b10110;
            4'd10:   code = 5'b11001;
            4'd11:   code = 5'b00100;
            4'd12:   code = 5'b01010;
            4'd13:   code = 5'b01011;
            4'd14:   code = 5'b01100;
            default: code = 5'b01101;
        endcase
        return code;
    endfunction

    always_comb begin
        col_last  = (cyc_q == CYC_LAST);
        cyc_d     = col_last ? '0 : cyc_q + CYC_W'(1);
        col_idx_d = col_last ? col_idx_q + 2'd1 : col_idx_q;
        col_d     = ~(4'b0001 << col_idx_d);
        keymap_d  = keymap_q;
        if (col_last) begin
            keymap_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
        end
        // The map is complete one cycle after column 3 is latched.
        eval_d    = col_last && (col_idx_q == 2'd3);
    end

    always_comb begin
        key_count   = count_keys(keymap_q);
        key_idx     = key_index(keymap_q);
        scan_none   = (key_count == 5'd0);
        scan_single = (key_count == 5'd1);
        cnt_inc     = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        newkey_d  = 1'b0;
        keycode_d = keycode_q;
        if (eval_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_single) begin
                        cand_d  = key_idx;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (scan_single && (key_idx == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            newkey_d  = 1'b1;
                            keycode_d = key_code(cand_q);
                            cnt_d     = '0;
                            state_d   = ST_HELD;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (scan_none) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (scan_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_HELD;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
            cyc_q      <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            keymap_q   <= '0;
            eval_q     <= 1'b0;
            state_q    <= ST_IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            newkey_q   <= 1'b0;
            keycode_q  <= 5'b00000;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            cyc_q      <= cyc_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            keymap_q   <= keymap_d;
            eval_q     <= eval_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            newkey_q   <= newkey_d;
            keycode_q  <= keycode_d;
        end
    end

    assign col     = col_q;
    assign newKey  = newkey_q;
    assign keyCode = keycode_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model on the col/row pins, scan-level stimulus and a
// whole-scan debounce model compared against the DUT outputs on every cycle.
module tb_keypad_scan;

    localparam int SC   = 4;
    localparam int DS   = 3;
    localparam int SCAN = 4 * SC;

    logic       clock;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic       newKey;
    logic [4:0] keyCode;

    logic [15:0] pressed;
    string       layout = "1470258F369EABCD";

    int checks = 0;
    int errors = 0;

    // Observations shared with the stimulus process.
    int         pulses    = 0;
    int         last_cyc  = -1;
    logic [4:0] last_code = 5'b00000;

    // Model state.
    int          cyc       = 0;
    bit          armed     = 1'b1;
    int          run_key   = 0;
    int          run_len   = 0;
    int          quiet_len = 0;
    int          rep_cyc   = -1;
    logic [4:0]  rep_code  = 5'b00000;
    logic [4:0]  exp_code  = 5'b00000;
    logic [15:0] prev_scan = '0;
    bit          rst_prev  = 1'b0;

    keypad_scan #(
        .SETTLE_CYCLES (SC),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .row    (row),
        .col    (col),
        .newKey (newKey),
        .keyCode(keyCode)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[c*4+r]) row[r] = 1'b0;
                end
            end
        end
    end

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [4:0] char_code(byte ch);
        if (ch >= "0" && ch <= "9") return {1'b1, 4'(ch - "0")};
        if (ch == "E") return 5'b00100;
        return {1'b0, 4'(ch - "A" + 10)};
    endfunction

    function automatic logic [15:0] kb(byte ch);
        for (int i = 0; i < 16; i++) begin
            if (layout[i] == ch) return 16'(1) << i;
        end
        return 16'h0000;
    endfunction

    // One evaluation of a whole-scan result: accept after DS identical single-key scans,
    // re-arm after DS empty scans.
    task automatic model_step(input logic [15:0] m, input int now);
        int n;
        int k;
        n = $countones(m);
        k = 0;
        for (int i = 0; i < 16; i++) if (m[i]) k = i;
        if (armed) begin
            if (n == 1) begin
                if (run_len == 0) begin
                    run_key = k;
                    run_len = 1;
                end else if (k == run_key) begin
                    run_len++;
                end else begin
                    run_len = 0;
                end
                if (run_len == DS) begin
                    armed     = 1'b0;
                    quiet_len = 0;
                    run_len   = 0;
                    rep_cyc   = now + 1;
                    rep_code  = char_code(layout[k]);
                end
            end else begin
                run_len = 0;
            end
        end else begin
            if (n == 0) begin
                quiet_len++;
                if (quiet_len == DS) begin
                    armed   = 1'b1;
                    run_len = 0;
                end
            end else begin
                quiet_len = 0;
            end
        end
    endtask

    initial begin
        logic [3:0] exp_col;
        bit         exp_nk;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (rst_prev) begin
                    chk("rst_col", int'(col), int'(4'b1110));
                    chk("rst_newKey", int'(newKey), 0);
                    chk("rst_keyCode", int'(keyCode), 0);
                end
                cyc       = 0;
                armed     = 1'b1;
                run_len   = 0;
                quiet_len = 0;
                rep_cyc   = -1;
                exp_code  = 5'b00000;
            end else begin
                exp_nk = (cyc == rep_cyc);
                if (exp_nk) exp_code = rep_code;
                exp_col = 4'b1111;
                exp_col[(cyc / SC) % 4] = 1'b0;
                chk("col", int'(col), int'(exp_col));
                chk("newKey", int'(newKey), int'(exp_nk));
                chk("keyCode", int'(keyCode), int'(exp_code));
                if (newKey) begin
                    pulses++;
                    last_cyc  = cyc;
                    last_code = keyCode;
                end
                if (cyc % SCAN == 0) begin
                    if (cyc > 0) model_step(prev_scan, cyc);
                    prev_scan = pressed;
                end
                cyc++;
            end
            rst_prev = reset;
        end
    end

    task automatic scan(input logic [15:0] keys, input int n);
        for (int i = 0; i < n; i++) begin
            pressed = keys;
            repeat (SCAN) @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("reset_col", int'(col), int'(4'b1110));
        chk("reset_newKey", int'(newKey), 0);
        chk("reset_keyCode", int'(keyCode), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int         p0;
        int         kind;
        int         len;
        int         a;
        logic [15:0] m;
        logic [15:0] last_key;

        reset   = 1'b1;
        pressed = '0;
        do_reset();

        // Idle scanning after reset
        p0 = pulses;
        scan('0, 13);
        chk("idle_pulses", pulses - p0, 0);
        chk("idle_keyCode", int'(keyCode), 0);

        // Single press of "1" right after reset
        do_reset();
        p0 = pulses;
        scan(kb("1"), 4);
        chk("single_count", pulses - p0, 1);
        chk("single_cycle", last_cyc, 49);
        chk("single_code", int'(last_code), int'(5'b10001));
        scan(kb("1"), 10);
        chk("single_no_repeat", pulses - p0, 1);
        scan('0, 5);

        // Digit and control keys
        p0 = pulses;
        scan(kb("0"), 5);
        chk("key0_code", int'(last_code), int'(5'b10000));
        scan('0, 5);
        scan(kb("C"), 5);
        chk("keyC_code", int'(last_code), int'(5'b01100));
        scan('0, 5);
        scan(kb("E"), 5);
        chk("keyE_code", int'(last_code), int'(5'b00100));
        scan('0, 5);
        chk("keys_count", pulses - p0, 3);

        // Bounce on "5"
        p0 = pulses;
        scan(kb("5"), 2);
        scan('0, 1);
        scan(kb("5"), 2);
        chk("bounce_early", pulses - p0, 0);
        scan(kb("5"), 2);
        chk("bounce_count", pulses - p0, 1);
        chk("bounce_code", int'(last_code), int'(5'b10101));
        scan('0, 5);

        // Two keys together, then one released
        p0 = pulses;
        scan(kb("2") | kb("A"), 6);
        chk("multi_none", pulses - p0, 0);
        scan(kb("2"), 4);
        chk("multi_then_single", pulses - p0, 1);
        chk("multi_code", int'(last_code), int'(5'b10010));
        scan('0, 5);

        // Short release, then reset with the key still held
        p0 = pulses;
        scan(kb("9"), 4);
        chk("k9_first", pulses - p0, 1);
        scan('0, 2);
        scan(kb("9"), 3);
        chk("k9_short_release", pulses - p0, 1);
        do_reset();
        scan(kb("9"), 4);
        chk("k9_after_reset", pulses - p0, 2);
        chk("k9_reset_cycle", last_cyc, 49);
        chk("k9_reset_code", int'(last_code), int'(5'b11001));
        scan('0, 5);

        // Randomised scan-level traffic
        last_key = kb("7");
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 5);
            if (kind < 3) begin
                m = '0;
            end else if (kind < 6) begin
                m = last_key;
            end else if (kind < 9) begin
                m        = 16'(1) << $urandom_range(0, 15);
                last_key = m;
            end else begin
                a = $urandom_range(0, 15);
                m = (16'(1) << a) | (16'(1) << ((a + 1 + $urandom_range(0, 14)) % 16));
            end
            scan(m, len);
        end
        scan('0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
